// File: rtl/lcd_ctrl.sv
// ============================================================================
// Module   : lcd_ctrl
// Brief    : Write-only HD44780 character LCD controller. Runs the power-up
//            wait and the 4-command init sequence, then accepts command/data
//            write requests and sequences RS/DATA setup, the EN pulse, hold and
//            the post-write execution wait.
// Options  : LCD_CTRL_FIFO_EN - adds a 4-entry request FIFO in front of the FSM
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ctrl #(
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 4,
    parameter int EN_CYC       = 25,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_vld,
    output logic       o_req_rdy,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_busy,
    output logic       o_init_done,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rw,
    output logic       o_lcd_rs,
    output logic       o_lcd_en,
    output logic       o_lcd_on
);

    // One shared counter, wide enough for the longest interval.
    localparam int c_max_0 = (PWRUP_CYC > SETUP_CYC) ? PWRUP_CYC : SETUP_CYC;
    localparam int c_max_1 = (c_max_0 > EN_CYC) ? c_max_0 : EN_CYC;
    localparam int c_max_2 = (c_max_1 > CMD_WAIT_CYC) ? c_max_1 : CMD_WAIT_CYC;
    localparam int c_max   = (c_max_2 > CLR_WAIT_CYC) ? c_max_2 : CLR_WAIT_CYC;
    localparam int CNT_W   = $clog2(c_max + 1);

    // The reset cycle is count 0 of power-up, so PWRUP ends once PWRUP_CYC
    // non-reset cycles have elapsed; every other state ends at duration-1.
    localparam logic [CNT_W-1:0] c_pwrup_end = CNT_W'(PWRUP_CYC);
    localparam logic [CNT_W-1:0] c_setup_end = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_en_end    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] c_cmd_end   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] c_clr_end   = CNT_W'(CLR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_WAIT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       idx_q,   idx_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;
    logic             en_q,    en_d;
    logic             rs_q,    rs_d;
    logic [7:0]       data_q,  data_d;
    logic             on_q,    on_d;

    logic             w_pending;
    logic             w_req_rs;
    logic [7:0]       w_req_data;
    logic             w_long_wait;

    // Init command table: function set 8-bit/2-line, display on, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

`ifdef LCD_CTRL_FIFO_EN
    logic [3:0][8:0] mem_q,   mem_d;
    logic [1:0]      f_wr_q,  f_wr_d;
    logic [1:0]      f_rd_q,  f_rd_d;
    logic [2:0]      f_cnt_q, f_cnt_d;
    logic            w_push;
    logic            w_pop;
    logic            w_full;

    assign w_full     = (f_cnt_q == 3'd4);
    assign w_pending  = (f_cnt_q != 3'd0);
    assign w_pop      = (state_q == ST_IDLE) && w_pending;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign o_req_rdy  = done_q && (!w_full || w_pop);
    assign w_push     = i_req_vld && o_req_rdy;
    assign w_req_rs   = mem_q[f_rd_q][8];
    assign w_req_data = mem_q[f_rd_q][7:0];

    // FIFO next-state: write at the tail on push, advance the head on pop.
    always_comb begin
        mem_d   = mem_q;
        f_wr_d  = f_wr_q;
        f_rd_d  = f_rd_q;
        f_cnt_d = f_cnt_q;
        if (w_push) begin
            mem_d[f_wr_q] = {i_req_rs, i_req_data};
            f_wr_d        = f_wr_q + 2'd1;
        end
        if (w_pop) begin
            f_rd_d = f_rd_q + 2'd1;
        end
        case ({w_push, w_pop})
            2'b10:   f_cnt_d = f_cnt_q + 3'd1;
            2'b01:   f_cnt_d = f_cnt_q - 3'd1;
            default: f_cnt_d = f_cnt_q;
        endcase
    end

    // FIFO registers; reset discards anything queued.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mem_q   <= '0;
            f_wr_q  <= 2'd0;
            f_rd_q  <= 2'd0;
            f_cnt_q <= 3'd0;
        end else begin
            mem_q   <= mem_d;
            f_wr_q  <= f_wr_d;
            f_rd_q  <= f_rd_d;
            f_cnt_q <= f_cnt_d;
        end
    end
`else
    // Without a FIFO the requester holds the request until IDLE takes it.
    assign o_req_rdy  = done_q && (state_q == ST_IDLE);
    assign w_pending  = i_req_vld;
    assign w_req_rs   = i_req_rs;
    assign w_req_data = i_req_data;
`endif

    // Clear and return-home need the long execution wait.
    assign w_long_wait = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) ||
                                   (data_q == 8'h03));

    // FSM next-state, counter and registered pin values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        done_d  = done_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == c_pwrup_end) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (w_pending) begin
                    state_d = ST_SETUP;
                    rs_d    = w_req_rs;
                    data_d  = w_req_data;
                end
            end
            ST_SETUP: begin
                if (cnt_q == c_setup_end) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == c_en_end) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == (w_long_wait ? c_clr_end : c_cmd_end)) begin
                    cnt_d = '0;
                    if (done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        data_d  = init_cmd(idx_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase
        en_d   = (state_d == ST_PULSE);
        busy_d = (state_d != ST_IDLE);
        on_d   = 1'b1;
    end

    // State and output registers; reset forces every pin low and restarts power-up.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_PWRUP;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            on_q    <= on_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_init_done = done_q;
    assign o_lcd_data  = data_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_on    = on_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
// ============================================================================
// Module   : tb_lcd_ctrl
// Brief    : Self-checking bench for lcd_ctrl. Expected writes are queued when
//            a request is handed over; a pin monitor pops them on each EN rise
//            and checks setup, pulse width, hold and wait lengths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_ctrl;

    localparam int P  = 10;
    localparam int S  = 2;
    localparam int E  = 3;
    localparam int CW = 5;
    localparam int LW = 20;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       vld    = 1'b0;
    logic       rs     = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       o_req_rdy, o_busy, o_init_done;
    logic [7:0] o_lcd_data;
    logic       o_lcd_rw, o_lcd_rs, o_lcd_en, o_lcd_on;

    lcd_ctrl #(
        .PWRUP_CYC    (P),
        .SETUP_CYC    (S),
        .EN_CYC       (E),
        .CMD_WAIT_CYC (CW),
        .CLR_WAIT_CYC (LW)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_vld   (vld),
        .o_req_rdy   (o_req_rdy),
        .i_req_rs    (rs),
        .i_req_data  (data),
        .o_busy      (o_busy),
        .o_init_done (o_init_done),
        .o_lcd_data  (o_lcd_data),
        .o_lcd_rw    (o_lcd_rw),
        .o_lcd_rs    (o_lcd_rs),
        .o_lcd_en    (o_lcd_en),
        .o_lcd_on    (o_lcd_on)
    );

    always #5 clk = ~clk;

    // gap  = busy, EN-low cycles seen just before EN rises
    // tail = busy, EN-low cycles after EN falls until busy drops (0 = none)
    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
        int         tail;
    } exp_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int wait_of(input logic r, input logic [7:0] d);
        if (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return LW;
        return CW;
    endfunction

    task automatic push_init();
        sb.push_back('{1'b0, 8'h38, P + S, 0});
        sb.push_back('{1'b0, 8'h0C, 1 + CW + S, 0});
        sb.push_back('{1'b0, 8'h01, 1 + CW + S, 0});
        sb.push_back('{1'b0, 8'h06, 1 + LW + S, 1 + CW});
    endtask

    // Pin monitor
    int         lo_cnt, en_cnt, last_tail;
    logic       prev_en, prev_busy, have_cur;
    logic [8:0] h1, h2;
    exp_t       cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            lo_cnt = 0; en_cnt = 0; last_tail = 0;
            prev_en = 1'b0; prev_busy = 1'b0; have_cur = 1'b0;
            h1 = '0; h2 = '0;
        end else begin
            chk("lcd_rw", int'(o_lcd_rw), 0);
            if (!o_init_done) chk("rdy_before_init", int'(o_req_rdy), 0);
            if (o_busy || o_init_done) chk("lcd_on", int'(o_lcd_on), 1);
            if (o_lcd_en && !prev_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_en", 1, 0);
                    have_cur = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    chk("en_rs", int'(o_lcd_rs), int'(cur.rs));
                    chk("en_data", int'(o_lcd_data), int'(cur.data));
                    chk("setup_gap", lo_cnt, cur.gap);
                    chk("setup_stable1", int'(h1), int'({cur.rs, cur.data}));
                    chk("setup_stable2", int'(h2), int'({cur.rs, cur.data}));
                    last_tail = cur.tail;
                end
            end
            if (have_cur && (o_lcd_en || prev_en))
                chk("pulse_hold_stable", int'({o_lcd_rs, o_lcd_data}), int'({cur.rs, cur.data}));
            if (o_lcd_en) en_cnt++;
            if (!o_lcd_en && prev_en) begin
                chk("en_width", en_cnt, E);
                en_cnt = 0;
            end
            if (!o_busy && prev_busy) begin
                if (last_tail != 0) chk("wait_len", lo_cnt, last_tail);
                chk("done_at_idle", int'(o_init_done), 1);
                last_tail = 0;
            end
            if (o_busy && !o_lcd_en) lo_cnt++;
            else lo_cnt = 0;
            h2 = h1;
            h1 = {o_lcd_rs, o_lcd_data};
            prev_en = o_lcd_en;
            prev_busy = o_busy;
        end
    end

    // Present a request at a negedge and wait (bounded) for acceptance;
    // returns the number of negedges spent stalled.
    task automatic send(input logic r, input logic [7:0] d, input bit keep,
                        output int stalled);
        bit ok;
        ok = 1'b0;
        stalled = 0;
        vld = 1'b1; rs = r; data = d;
        for (int i = 0; i < 500; i++) begin
            if (o_req_rdy) begin
                sb.push_back('{r, d, S, 1 + wait_of(r, d)});
                @(posedge clk);
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            stalled++;
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 1, 0);
        if (!keep) vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!o_busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 1, 0);
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_en"},   int'(o_lcd_en), 0);
        chk({tag, "_on"},   int'(o_lcd_on), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_init_done), 0);
        chk({tag, "_rdy"},  int'(o_req_rdy), 0);
        chk({tag, "_data"}, int'({o_lcd_rs, o_lcd_data}), 0);
    endtask

    initial begin
        int st;
        bit ok;
        vecs[0] = '{1'b1, 8'h41};
        vecs[1] = '{1'b0, 8'h01};
        vecs[2] = '{1'b0, 8'h80};
        vecs[3] = '{1'b0, 8'h02};
        vecs[4] = '{1'b0, 8'h03};
        vecs[5] = '{1'b0, 8'h04};
        vecs[6] = '{1'b0, 8'h00};
        vecs[7] = '{1'b1, 8'h01};
        vecs[8] = '{1'b1, 8'h02};
        vecs[9] = '{1'b0, 8'hFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_pins("reset");

        // Power-up and init with a request already waiting
        push_init();
        rst_n = 1'b1;
        send(1'b1, 8'h55, 1'b0, st);
        chk("init_stall", int'(st > P), 1);
        wait_idle();

        // Table-driven single writes
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].rs, vecs[i].data, 1'b0, st);
            wait_idle();
        end

`ifndef LCD_CTRL_FIFO_EN
        // Back-to-back requests: the second stalls through the first write
        send(1'b0, 8'hC0, 1'b1, st);
        send(1'b1, 8'h48, 1'b0, st);
        chk("b2b_stall", st, S + E + 1 + CW);
        wait_idle();
`else
        // Burst of six: the FIFO fills and back-pressures, order preserved
        begin
            int total;
            total = 0;
            for (int i = 0; i < 6; i++) begin
                send(1'b1, 8'h30 + 8'(i), 1'b1, st);
                total += st;
            end
            vld = 1'b0;
            chk("fifo_backpressure", int'(total > 0), 1);
            wait_idle();
        end
`endif

        // Reset on the second EN cycle, then full re-init
        send(1'b0, 8'h0F, 1'b0, st);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (o_lcd_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("pulse_timeout", 1, 0);
        @(negedge clk);
        chk("second_pulse_en", int'(o_lcd_en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_pins("midpulse");
        sb.delete();
        @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_idle();
        chk("reinit_done", int'(o_init_done), 1);
        send(1'b1, 8'h7A, 1'b0, st);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
